alu_multicycle: RTL and testbench

- Parametrised iterative multiply/divide unit for the stack CPU.
- Extends the single-cycle combinational ALU with double-width multiply and divide-with-remainder (UM*, M*, UM/MOD, SM/REM), which cannot complete in one cycle.
- Sits beside the single-cycle ALU. The core issues an operation with `start` and stalls on `busy`. On `done` it takes `result_low`/`result_high` into data stack top/second.

---
 rtl/alu_multicycle_if.sv | 26 ++
 rtl/alu_multicycle.sv | 146 ++++++++++++++
 tb/tb_alu_multicycle.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Issue/result bundle between the stack CPU core and the iterative multiply/divide unit.
// The core drives the request side as master; the unit answers as slave.
interface alu_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             flush;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_low;
  logic [WIDTH-1:0] result_high;
  logic             div_by_zero;

  modport master (
    output flush, start, op, operand_a, operand_b,
    input  busy, done, result_low, result_high, div_by_zero
  );

  modport slave (
    input  flush, start, op, operand_a, operand_b,
    output busy, done, result_low, result_high, div_by_zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Iterative multiply/divide unit: one result bit per cycle on operand magnitudes,
// with the sign fix-up folded into the last RUN cycle so it costs no extra latency.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         reset,
  alu_multicycle_if.slave bus
);
  localparam int COUNT_BITS = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [COUNT_BITS-1:0]   r_count;
  logic [1:0]              r_op;
  logic [2*WIDTH-1:0]      r_acc;
  logic [WIDTH-1:0]        r_opB;
  logic                    r_negLow;
  logic                    r_negHigh;
  logic [WIDTH-1:0]        r_resLow;
  logic [WIDTH-1:0]        r_resHigh;
  logic                    r_dbz;

  logic                    w_accept;
  logic                    w_zeroDiv;
  logic                    w_lastStep;
  logic [WIDTH-1:0]        w_magA;
  logic [WIDTH-1:0]        w_magB;
  logic [WIDTH:0]          w_mulSum;
  logic [2*WIDTH-1:0]      w_mulNext;
  logic [WIDTH:0]          w_divShift;
  logic                    w_divFits;
  logic [WIDTH-1:0]        w_divDiff;
  logic [2*WIDTH-1:0]      w_divNext;
  logic [2*WIDTH-1:0]      w_accNext;
  logic [2*WIDTH-1:0]      w_mulSigned;
  logic [WIDTH-1:0]        w_quo;
  logic [WIDTH-1:0]        w_rem;
  logic [WIDTH-1:0]        w_resLow;
  logic [WIDTH-1:0]        w_resHigh;

  // Requests are only taken when not iterating; flush cancels any acceptance.
  always_comb begin
    w_accept   = (r_state != S_RUN) && bus.start && !bus.flush;
    w_zeroDiv  = w_accept && bus.op[1] && (bus.operand_b == '0);
    w_lastStep = (r_state == S_RUN) && (r_count == COUNT_BITS'(WIDTH - 1)) && !bus.flush;
    w_magA     = (bus.op[0] && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
    w_magB     = (bus.op[0] && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: w_stateNext = w_accept ? (w_zeroDiv ? S_DONE : S_RUN) : S_IDLE;
      S_RUN:          if (w_lastStep) w_stateNext = S_DONE;
      default:        w_stateNext = S_IDLE;
    endcase
    if (bus.flush) begin
      w_stateNext = S_IDLE;
    end
  end

  // Accumulator: multiplier shifts out of the low half while the product grows in the
  // high half; for division the high half is the partial remainder and the low half
  // turns from dividend into quotient.
  always_comb begin
    w_mulSum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opB} : '0);
    w_mulNext   = {w_mulSum, r_acc[WIDTH-1:1]};
    w_divShift  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_divFits   = w_divShift >= {1'b0, r_opB};
    w_divDiff   = w_divShift[WIDTH-1:0] - r_opB;
    w_divNext   = {(w_divFits ? w_divDiff : w_divShift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_divFits};
    w_accNext   = r_op[1] ? w_divNext : w_mulNext;
    w_mulSigned = r_negLow ? -w_accNext : w_accNext;
    w_quo       = w_accNext[WIDTH-1:0];
    w_rem       = w_accNext[2*WIDTH-1:WIDTH];
    if (r_op[1]) begin
      w_resLow  = r_negLow ? -w_quo : w_quo;
      w_resHigh = r_negHigh ? -w_rem : w_rem;
    end else begin
      w_resLow  = w_mulSigned[WIDTH-1:0];
      w_resHigh = w_mulSigned[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_op      <= '0;
      r_acc     <= '0;
      r_opB     <= '0;
      r_negLow  <= 1'b0;
      r_negHigh <= 1'b0;
      r_resLow  <= '0;
      r_resHigh <= '0;
      r_dbz     <= 1'b0;
    end else if (!bus.flush) begin
      if (w_accept) begin
        r_op      <= bus.op;
        r_count   <= '0;
        r_negLow  <= bus.op[0] && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
        r_negHigh <= bus.op[0] && bus.op[1] && bus.operand_a[WIDTH-1];
        if (bus.op[1]) begin
          r_acc <= {{WIDTH{1'b0}}, w_magA};
          r_opB <= w_magB;
        end else begin
          r_acc <= {{WIDTH{1'b0}}, w_magB};
          r_opB <= w_magA;
        end
        if (w_zeroDiv) begin
          r_resLow  <= '1;
          r_resHigh <= bus.operand_a;
          r_dbz     <= 1'b1;
        end
      end else if (r_state == S_RUN) begin
        r_acc   <= w_accNext;
        r_count <= r_count + COUNT_BITS'(1);
        if (w_lastStep) begin
          r_resLow  <= w_resLow;
          r_resHigh <= w_resHigh;
          r_dbz     <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = (r_state == S_RUN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.result_low  = r_resLow;
  assign bus.result_high = r_resHigh;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: fixed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for start-while-busy, flush and async reset.
module tb_alu_multicycle;
  localparam int W = 16;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expLow;
    logic [W-1:0] expHigh;
    logic         expDbz;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [W-1:0] lastLow;
  logic [W-1:0] lastHigh;
  logic         lastDbz;
  vec_t vecs[12];

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definitions, using 64-bit integers.
  function automatic void refModel(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dbz);
    longint ua, ub, sa, sb;
    logic [63:0] p, q, r;
    ua  = {48'b0, a};
    ub  = {48'b0, b};
    sa  = {{48{a[W-1]}}, a};
    sb  = {{48{b[W-1]}}, b};
    dbz = 1'b0;
    lo  = '0;
    hi  = '0;
    if (op == 2'b00) begin
      p = ua * ub;
      lo = p[15:0];
      hi = p[31:16];
    end else if (op == 2'b01) begin
      p = sa * sb;
      lo = p[15:0];
      hi = p[31:16];
    end else if (b == '0) begin
      lo  = '1;
      hi  = a;
      dbz = 1'b1;
    end else if (op == 2'b10) begin
      q = ua / ub;
      r = ua % ub;
      lo = q[15:0];
      hi = r[15:0];
    end else begin
      q = sa / sb;
      r = sa % sb;
      lo = q[15:0];
      hi = r[15:0];
    end
  endfunction

  // Issues one op (called #1 after an edge) and returns in the cycle done is seen.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int pulseAt, output int lat, output int busyCnt, output bit timedOut);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.op        = 2'($urandom);
    bus.operand_a = W'($urandom);
    bus.operand_b = W'($urandom);
    lat     = 0;
    busyCnt = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) busyCnt++;
      bus.start = (lat == pulseAt);
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    timedOut  = !bus.done;
  endtask

  task automatic doOp(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input int pulseAt, input logic [W-1:0] eLo, input logic [W-1:0] eHi, input logic eDbz);
    int lat, busyCnt;
    bit timedOut;
    applyStimulus(op, a, b, pulseAt, lat, busyCnt, timedOut);
    if (timedOut) begin
      checkOutput({tag, ".done"}, 64'(bus.done), 64'd1);
    end else begin
      checkOutput({tag, ".low"}, 64'(bus.result_low), 64'(eLo));
      checkOutput({tag, ".high"}, 64'(bus.result_high), 64'(eHi));
      checkOutput({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(eDbz));
      checkOutput({tag, ".latency"}, 64'(lat), eDbz ? 64'd0 : 64'(W));
      checkOutput({tag, ".busyCycles"}, 64'(busyCnt), eDbz ? 64'd0 : 64'(W));
    end
    lastLow  = eLo;
    lastHigh = eHi;
    lastDbz  = eDbz;
  endtask

  initial begin
    logic [W-1:0] mLo, mHi;
    logic         mDbz;
    bit           sawDone;

    vecs[0]  = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
    vecs[1]  = '{2'b01, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0};
    vecs[2]  = '{2'b01, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b0};
    vecs[3]  = '{2'b10, 16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0};
    vecs[4]  = '{2'b10, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
    vecs[5]  = '{2'b11, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
    vecs[6]  = '{2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
    vecs[7]  = '{2'b10, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    vecs[8]  = '{2'b00, 16'h0002, 16'h0003, 16'h0006, 16'h0000, 1'b0};
    vecs[9]  = '{2'b11, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
    vecs[10] = '{2'b01, 16'h7FFF, 16'h8000, 16'h8000, 16'hC000, 1'b0};
    vecs[11] = '{2'b11, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1};

    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.flush     = 1'b0;
    bus.start     = 1'b0;
    bus.op        = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    #12;
    checkOutput("reset.busy", 64'(bus.busy), 64'd0);
    checkOutput("reset.done", 64'(bus.done), 64'd0);
    checkOutput("reset.low", 64'(bus.result_low), 64'd0);
    checkOutput("reset.high", 64'(bus.result_high), 64'd0);
    checkOutput("reset.dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Table vectors run back-to-back: each new start lands in the previous DONE cycle.
    for (int i = 0; i < 12; i++) begin
      doOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, -1,
           vecs[i].expLow, vecs[i].expHigh, vecs[i].expDbz);
    end

    @(posedge clk); #1;
    checkOutput("donePulse.done", 64'(bus.done), 64'd0);
    checkOutput("donePulse.busy", 64'(bus.busy), 64'd0);
    checkOutput("hold.low", 64'(bus.result_low), 64'(lastLow));
    checkOutput("hold.high", 64'(bus.result_high), 64'(lastHigh));

    doOp("midStart", 2'b00, 16'h0102, 16'h0304, 3, 16'h0A08, 16'h0003, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      int           pick, pulseAt;
      op   = 2'($urandom_range(0, 3));
      a    = W'($urandom);
      b    = W'($urandom);
      pick = $urandom_range(0, 9);
      if (pick == 0) b = '0;
      if (pick == 1) b = '1;
      if (pick == 2) a = 16'h8000;
      if (pick == 3) b = 16'h0001;
      pulseAt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, W - 2) : -1;
      refModel(op, a, b, mLo, mHi, mDbz);
      doOp($sformatf("rand%0d", n), op, a, b, pulseAt, mLo, mHi, mDbz);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end

    // Flush in RUN cycle 5 after a divide-by-zero: no done, previous results kept.
    doOp("preFlush", 2'b10, 16'h4321, 16'h0000, -1, 16'hFFFF, 16'h4321, 1'b1);
    bus.start     = 1'b1;
    bus.op        = 2'b00;
    bus.operand_a = 16'h1111;
    bus.operand_b = 16'h2222;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checkOutput("flush.busy", 64'(bus.busy), 64'd0);
    sawDone = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) sawDone = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("flush.noDone", 64'(sawDone), 64'd0);
    checkOutput("flush.low", 64'(bus.result_low), 64'(lastLow));
    checkOutput("flush.high", 64'(bus.result_high), 64'(lastHigh));
    checkOutput("flush.dbz", 64'(bus.div_by_zero), 64'(lastDbz));

    // Asynchronous reset between edges while iterating.
    bus.start     = 1'b1;
    bus.op        = 2'b00;
    bus.operand_a = 16'hFFFF;
    bus.operand_b = 16'hFFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncReset.busy", 64'(bus.busy), 64'd0);
    checkOutput("asyncReset.done", 64'(bus.done), 64'd0);
    checkOutput("asyncReset.low", 64'(bus.result_low), 64'd0);
    checkOutput("asyncReset.high", 64'(bus.result_high), 64'd0);
    checkOutput("asyncReset.dbz", 64'(bus.div_by_zero), 64'd0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("postReset.busy", 64'(bus.busy), 64'd0);
    doOp("postReset", 2'b11, 16'hFF9C, 16'h0007, -1, 16'hFFF2, 16'hFFFE, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
